// File: rtl/map9v3_unmap.sv
// Decoder for the map9v3 LFSR mapper: re-runs the 8-bit XNOR LFSR from SEED
// until it equals dp[8:1]; the step count becomes N[8:1] and N[0] is dp[0].
//
// state  | meaning
// IDLE   | waiting for a start edge
// LOAD   | seed the LFSR and clear the step counter
// SEARCH | compare sr to the target, step until hit or MAXSTEP
// DONE   | result held on N/err/done until the next start edge
module map9v3_unmap #(
  parameter logic [7:0] SEED    = 8'h00,
  parameter int         MAXSTEP = 254
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] dp,
  output logic [8:0] N,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [7:0] counter,
  output logic [7:0] sr
);

  localparam logic [7:0] MAX_CNT = 8'(MAXSTEP);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

  state_t     state, state_nx;
  logic       s0, s1;
  logic       start_edge;
  logic [8:0] target;
  logic [7:0] sr_nx;
  logic       hit;
  logic       last;

  assign start_edge = s0 & ~s1;
  assign sr_nx      = {sr[6:0], ~(sr[7] ^ sr[5] ^ sr[4] ^ sr[3])};
  assign hit        = (sr == target[8:1]);
  assign last       = (counter == MAX_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= start;
      s1 <= s0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Edges arriving in LOAD/SEARCH are dropped, not queued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_edge) state_nx = LOAD;
      LOAD:       state_nx = SEARCH;
      SEARCH:     if (hit || last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target  <= 9'd0;
      N       <= 9'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      counter <= 8'd0;
      sr      <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            target <= dp;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          sr      <= SEED;
          counter <= 8'd0;
        end
        SEARCH: begin
          // Hit is checked first so the smallest matching step wins.
          if (hit) begin
            N    <= {counter, target[0]};
            done <= 1'b1;
            busy <= 1'b0;
          end else if (last) begin
            N    <= 9'd0;
            err  <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            sr      <= sr_nx;
            counter <= counter + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/map9v3_unmap.md
Name: map9v3_unmap

Overview:
- Inverse of the map9v3 LFSR mapper. Takes a 9-bit mapped word dp = {sr_value[7:0], lsb} and recovers the original 9-bit N by re-running the same 8-bit LFSR from seed 0x00 until it matches sr_value.
- The step count becomes N[8:1]; N[0] passes through from dp[0].
- Sits beside map9v3 as its decoder and round-trip checker; same start-pulse style, same debug outputs.

Parameters:
- SEED, 8'h00, LFSR start value; must match the mapper.
- MAXSTEP, 254, last step index searched before declaring a miss (LFSR period 255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level from the host; rising edge launches a decode.
- dp  input  9  mapped word; sampled once at accept.
- N  output  9  recovered value {step_count, dp[0]}.
- done  output  1  result valid; level.
- busy  output  1  decode in progress.
- err  output  1  no match within MAXSTEP+1 compares.
- counter  output  8  live step count (debug).
- sr  output  8  live LFSR value (debug).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; N, counter, sr, target=0; done, busy, err=0; start sync flops=0.
- Start detect: 2-flop synchronizer s0 then s1. Edge = s0 & ~s1. An edge is acted on only in IDLE or DONE; edges seen in LOAD or SEARCH are ignored (dropped, not queued).
- LFSR step: sr_next = {sr[6:0], ~(sr[7]^sr[5]^sr[4]^sr[3])}.
  - XNOR, maximal length, period 255.
  - 0xFF is the lockup value and is unreachable from SEED.
- FSM, with E = the clock edge where the edge is accepted:
  - IDLE/DONE, edge: target <= dp; done <= 0; err <= 0; busy <= 1; state <= LOAD.
  - LOAD (1 cycle): sr <= SEED; counter <= 0; state <= SEARCH.
  - SEARCH, sr == target[8:1]: N <= {counter, target[0]}; done <= 1; busy <= 0; state <= DONE.
  - SEARCH, no match and counter == MAXSTEP: N <= 0; err <= 1; done <= 1; busy <= 0; state <= DONE.
  - SEARCH, otherwise: sr <= sr_next; counter <= counter + 1.
  - DONE: hold N, err and done until the next accepted edge. counter and sr hold their final values.
- Latency:
  - A match after k steps raises done at edge E+2+k (k = 0..254).
  - A miss raises done at edge E+256.
- Aliasing: an encoder run of 255 steps returns sr to SEED, so it decodes as step 0. The decoder always reports the smallest matching k.
- Counter width is 8 bits and never wraps; the search terminates at MAXSTEP.
- Reset asserted mid-search: immediate return to reset values; no partial result is kept.
- start held high: counts as a single edge; a new decode needs start low for at least 2 cycles first.
- dp changes after E have no effect on the running decode.

Test Plan:
- Reset then dp=9'h001, start rise -> done at E+2, N=9'h001, err=0, busy high for 2 cycles.
- dp=9'h002 (sr 0x01, k=1) -> N=9'h002 at E+3. dp=9'h01F (sr 0x0F, k=4) -> N=9'h009 at E+6. dp=9'h03C (sr 0x1E, k=5) -> N=9'h00A at E+7.
- dp=9'h1FF (sr 0xFF, lockup) -> done and err at E+256, N=9'h000. Next start clears err and done at its accept edge.
- Second start pulse during SEARCH for dp=9'h03C -> ignored; single result N=9'h00A; busy never re-pulses.
- reset low at E+4 of a k=200 decode -> all outputs 0 within the same cycle; a fresh decode after release completes normally.
- Round trip: for every N with N[8:1] <= 254, drive map9v3 with N and feed its dp into this block -> recovered N equals the original; scoreboard reports 0 mismatches.
